// File: rtl/adder_share_ctrl_pkg.sv
// Shared types for the time-shared add/sub unit: request and response records
// plus the native datapath width.
package add_share_pkg;

  localparam int ADD_WIDTH = 32;
  localparam int ADD_ID_W  = 3;

  typedef struct packed {
    logic [ADD_WIDTH-1:0] a;
    logic [ADD_WIDTH-1:0] b;
    logic                 sub;
    logic [ADD_ID_W-1:0]  id;
  } add_req_t;

  typedef struct packed {
    logic [ADD_WIDTH-1:0] sum;
    logic                 carry;
    logic                 ovf;
    logic [ADD_ID_W-1:0]  id;
  } add_rsp_t;

endpackage

// File: rtl/adder_share_ctrl_if.sv
// Request/response bundle between the requesters (master) and the shared adder
// controller (slave).
interface adder_share_ctrl_if import add_share_pkg::*; #(
  parameter int WIDTH = ADD_WIDTH,
  parameter int N_REQ = 3,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ-1:0]       req_sub;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [WIDTH-1:0]       rsp_sum;
  logic                   rsp_carry;
  logic                   rsp_overflow;

  modport master (
    output req_valid, req_a, req_b, req_sub, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_overflow
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sub, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_overflow
  );
endinterface

// File: rtl/adder_share_ctrl_ks_adder.sv
// Kogge-Stone prefix adder with built-in subtract (B inversion + carry-in);
// exposes the MSB generate/propagate and carry-in so the caller forms carry-out.
module kogge_stone_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub_en,
  output logic [WIDTH-1:0] sum,
  output logic             gen_msb,
  output logic             prop_msb,
  output logic             carry_msb,
  output logic             ovf
);
  localparam int LEVELS = $clog2(WIDTH);

  logic [WIDTH-1:0] bx, g0, p0, gk, pk, gn, pn, c;
  logic             cout;

  assign bx = b ^ {WIDTH{sub_en}};
  assign g0 = a & bx;
  assign p0 = a ^ bx;

  // gk[i]/pk[i] end up as group generate/propagate over bits [i:0]
  always_comb begin
    gk = g0;
    pk = p0;
    gn = g0;
    pn = p0;
    for (int l = 0; l < LEVELS; l++) begin
      gn = gk;
      pn = pk;
      for (int i = (1 << l); i < WIDTH; i++) begin
        gn[i] = gk[i] | (pk[i] & gk[i - (1 << l)]);
        pn[i] = pk[i] & pk[i - (1 << l)];
      end
      gk = gn;
      pk = pn;
    end
  end

  always_comb begin
    c    = '0;
    c[0] = sub_en;
    for (int i = 1; i < WIDTH; i++) c[i] = gk[i-1] | (pk[i-1] & sub_en);
    cout = gk[WIDTH-1] | (pk[WIDTH-1] & sub_en);
  end

  assign sum       = p0 ^ c;
  assign gen_msb   = g0[WIDTH-1];
  assign prop_msb  = p0[WIDTH-1];
  assign carry_msb = c[WIDTH-1];
  assign ovf       = cout ^ c[WIDTH-1];
endmodule

// File: rtl/adder_share_ctrl_rr_arbiter.sv
// Round-robin search: first asserted request at or above ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);
  logic found;
  int   idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end
endmodule

// File: rtl/adder_share_ctrl.sv
// Round-robin arbiter sharing one prefix adder: operand register (S1), adder,
// result register (S2), with valid/ready on both sides.
module adder_share_ctrl import add_share_pkg::*; #(
  parameter int WIDTH = ADD_WIDTH,
  parameter int N_REQ = 3,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input logic              clk,
  input logic              rst_n,
  adder_share_ctrl_if.slave bus
);
  add_req_t          s1_p1;
  logic              vld_p1;
  add_rsp_t          s2_p2;
  logic              vld_p2;
  add_req_t          req_sel;
  add_rsp_t          rsp_nxt;
  logic [ID_W-1:0]   ptr, grant_idx;
  logic [N_REQ-1:0]  grant;
  logic              s1_load, s2_load, handshake;
  logic [WIDTH-1:0]  add_sum;
  logic              gen_msb, prop_msb, carry_msb, adder_ovf_unused;

  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic sub, input logic sum_msb);
    logic bx;
    bx = b_msb ^ sub;
    return (a_msb == bx) && (sum_msb != a_msb);
  endfunction

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] idx);
    if (idx == ID_W'(N_REQ - 1)) return '0;
    return idx + ID_W'(1);
  endfunction

  rr_arbiter #(.N(N_REQ), .IW(ID_W)) u_arb (
    .req       (bus.req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign s2_load       = vld_p1 && (!vld_p2 || bus.rsp_ready);
  assign s1_load       = !vld_p1 || s2_load;
  assign bus.req_ready = grant & {N_REQ{s1_load && rst_n}};
  assign handshake     = |(bus.req_valid & bus.req_ready);

  always_comb begin
    req_sel     = '0;
    req_sel.a   = bus.req_a[grant_idx*WIDTH +: WIDTH];
    req_sel.b   = bus.req_b[grant_idx*WIDTH +: WIDTH];
    req_sel.sub = bus.req_sub[grant_idx];
    req_sel.id  = ADD_ID_W'(grant_idx);
  end

  // ---- S1 -> adder -> S2 ----
  kogge_stone_adder #(.WIDTH(WIDTH)) u_adder (
    .a         (s1_p1.a),
    .b         (s1_p1.b),
    .sub_en    (s1_p1.sub),
    .sum       (add_sum),
    .gen_msb   (gen_msb),
    .prop_msb  (prop_msb),
    .carry_msb (carry_msb),
    .ovf       (adder_ovf_unused)
  );

  always_comb begin
    rsp_nxt       = '0;
    rsp_nxt.sum   = add_sum;
    rsp_nxt.carry = gen_msb | (prop_msb & carry_msb);
    rsp_nxt.ovf   = signed_ovf(s1_p1.a[WIDTH-1], s1_p1.b[WIDTH-1], s1_p1.sub,
                               add_sum[WIDTH-1]);
    rsp_nxt.id    = s1_p1.id;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      ptr    <= '0;
      s2_p2  <= '0;
    end else begin
      if (s1_load) vld_p1 <= handshake;
      if (handshake) ptr <= next_ptr(grant_idx);
      if (s2_load) begin
        vld_p2 <= 1'b1;
        s2_p2  <= rsp_nxt;
      end else if (bus.rsp_ready) begin
        vld_p2 <= 1'b0;
      end
    end
  end

  // Operand register carries no reset: vld_p1 alone qualifies it
  always_ff @(posedge clk) begin
    if (handshake) s1_p1 <= req_sel;
  end

  // ---- S2 outputs ----
  assign bus.rsp_valid    = vld_p2;
  assign bus.rsp_id       = ID_W'(s2_p2.id);
  assign bus.rsp_sum      = s2_p2.sum;
  assign bus.rsp_carry    = s2_p2.carry;
  assign bus.rsp_overflow = s2_p2.ovf;
endmodule

// File: tb/tb_adder_share_ctrl.sv
// Directed bench for adder_share_ctrl with an arithmetic reference model and a
// per-cycle monitor for handshakes, ordering, latency and back-pressure.
module tb_adder_share_ctrl;
  import add_share_pkg::*;

  localparam int W  = 32;
  localparam int N  = 3;
  localparam int IW = 2;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    int          id;
    bit          lit;
    logic [31:0] lsum;
    logic        lc;
    logic        lo;
    bit          chk_lat;
    int          acc;
  } op_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adder_share_ctrl_if #(.WIDTH(W), .N_REQ(N), .ID_W(IW)) bus ();

  adder_share_ctrl #(.WIDTH(W), .N_REQ(N), .ID_W(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  op_t         pend[N][$];
  int          head[N];
  bit          acc_flag[N];
  op_t         exp_q[$];
  int          grant_log[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          ptr_m = 0;
  bit          prev_hold = 0;
  logic [31:0] h_sum;
  logic [IW-1:0] h_id;
  logic        h_c, h_o;
  logic [N-1:0] exp_rdy;
  bit          found;
  int          jj;
  op_t         e_mon, o_mon;
  logic [33:0] m_mon;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: {ovf, carry, sum} from plain unsigned/signed arithmetic.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    longint      sa, sb, r;
    logic [32:0] u;
    logic        o;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      u[31:0] = a - b;
      u[32]   = (a >= b);
      r       = sa - sb;
    end else begin
      u = {1'b0, a} + {1'b0, b};
      r = sa + sb;
    end
    o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    return {o, u};
  endfunction

  function automatic bit busy();
    for (int i = 0; i < N; i++) if (head[i] < pend[i].size()) return 1'b1;
    return exp_q.size() != 0;
  endfunction

  // Requester driver: each requester presents its queued operations in order.
  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sub   = '0;
    for (int i = 0; i < N; i++) head[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc_flag[i]) head[i]++;
        if (head[i] < pend[i].size()) begin
          bus.req_valid[i]      = 1'b1;
          bus.req_a[i*W +: W]   = pend[i][head[i]].a;
          bus.req_b[i*W +: W]   = pend[i][head[i]].b;
          bus.req_sub[i]        = pend[i][head[i]].sub;
        end else begin
          bus.req_valid[i]      = 1'b0;
          bus.req_a[i*W +: W]   = '0;
          bus.req_b[i*W +: W]   = '0;
          bus.req_sub[i]        = 1'b0;
        end
      end
    end
  end

  // Monitor: samples on the falling edge, between driver updates and DUT edges.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < N; i++) acc_flag[i] = 1'b0;
    if (!rst_n) begin
      check("ready_in_reset", 64'(bus.req_ready), 64'd0);
      exp_q.delete();
      ptr_m     = 0;
      prev_hold = 0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 64'(bus.rsp_valid), 64'd1);
        check("hold_sum", 64'(bus.rsp_sum), 64'(h_sum));
        check("hold_id", 64'(bus.rsp_id), 64'(h_id));
        check("hold_carry", 64'(bus.rsp_carry), 64'(h_c));
        check("hold_ovf", 64'(bus.rsp_overflow), 64'(h_o));
      end
      exp_rdy = '0;
      found   = 0;
      if (!(exp_q.size() == 2 && !bus.rsp_ready)) begin
        for (int k = 0; k < N; k++) begin
          jj = (ptr_m + k) % N;
          if (!found && bus.req_valid[jj]) begin
            exp_rdy[jj] = 1'b1;
            found       = 1;
          end
        end
      end
      check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected_valid", 64'(bus.rsp_valid), 64'd0);
        end else begin
          e_mon = exp_q.pop_front();
          m_mon = model(e_mon.a, e_mon.b, e_mon.sub);
          check("rsp_id", 64'(bus.rsp_id), 64'(e_mon.id));
          check("rsp_sum", 64'(bus.rsp_sum), 64'(m_mon[31:0]));
          check("rsp_carry", 64'(bus.rsp_carry), 64'(m_mon[32]));
          check("rsp_ovf", 64'(bus.rsp_overflow), 64'(m_mon[33]));
          if (e_mon.lit) begin
            check("lit_sum", 64'(bus.rsp_sum), 64'(e_mon.lsum));
            check("lit_carry", 64'(bus.rsp_carry), 64'(e_mon.lc));
            check("lit_ovf", 64'(bus.rsp_overflow), 64'(e_mon.lo));
          end
          if (e_mon.chk_lat) check("latency", 64'(cyc - e_mon.acc), 64'd2);
        end
      end
      for (int i = 0; i < N; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          o_mon     = pend[i][head[i]];
          o_mon.a   = bus.req_a[i*W +: W];
          o_mon.b   = bus.req_b[i*W +: W];
          o_mon.sub = bus.req_sub[i];
          o_mon.id  = i;
          o_mon.acc = cyc;
          exp_q.push_back(o_mon);
          grant_log.push_back(i);
          ptr_m       = (i + 1) % N;
          acc_flag[i] = 1'b1;
        end
      end
      prev_hold = bus.rsp_valid && !bus.rsp_ready;
      h_sum = bus.rsp_sum;
      h_id  = bus.rsp_id;
      h_c   = bus.rsp_carry;
      h_o   = bus.rsp_overflow;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input int r, input logic [31:0] a, input logic [31:0] b, input logic sub,
                      input bit lit, input logic [31:0] ls, input logic lc, input logic lo,
                      input bit lat);
    op_t o;
    o.a = a; o.b = b; o.sub = sub; o.id = r;
    o.lit = lit; o.lsum = ls; o.lc = lc; o.lo = lo;
    o.chk_lat = lat; o.acc = 0;
    pend[r].push_back(o);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int t;
    t = 0;
    while (t < budget && busy()) begin
      tick(1);
      t++;
    end
    check({name, "_drained"}, 64'(busy()), 64'd0);
  endtask

  initial begin
    int base;
    bus.rsp_ready = 1'b1;
    rst_n = 1'b0;
    tick(3);
    check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("reset_rsp_sum", 64'(bus.rsp_sum), 64'd0);
    check("reset_rsp_id", 64'(bus.rsp_id), 64'd0);
    rst_n = 1'b1;
    tick(1);

    push(0, 32'h5, 32'h3, 1'b0, 1, 32'h8, 1'b0, 1'b0, 1);
    wait_idle("add_basic", 30);

    push(1, 32'h7FFF_FFFF, 32'h1, 1'b0, 1, 32'h8000_0000, 1'b0, 1'b1, 1);
    push(1, 32'h8000_0000, 32'h1, 1'b1, 1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1);
    wait_idle("ovf_pair", 30);

    push(2, 32'h3, 32'h5, 1'b1, 1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1);
    push(2, 32'hFFFF_FFFF, 32'h1, 1'b0, 1, 32'h0, 1'b1, 1'b0, 1);
    wait_idle("carry_pair", 30);

    base = grant_log.size();
    for (int k = 0; k < 3; k++)
      for (int r = 0; r < N; r++)
        push(r, 32'h1000_0000 * (r + 1) + k, 32'h0123_4567 + r * 7 + k, 1'(k), 0, 0, 0, 0, 1);
    wait_idle("round_robin", 60);
    check("rr_count", 64'(grant_log.size() - base), 64'd9);
    for (int k = 0; k < 9; k++)
      if (base + k < grant_log.size())
        check("rr_order", 64'(grant_log[base + k]), 64'(k % N));

    bus.rsp_ready = 1'b0;
    push(0, 32'hA, 32'h4, 1'b1, 0, 0, 0, 0, 0);
    push(1, 32'h8000_0000, 32'h8000_0000, 1'b0, 0, 0, 0, 0, 0);
    push(0, 32'h1, 32'h2, 1'b1, 0, 0, 0, 0, 0);
    push(1, 32'h7FFF_0000, 32'h0001_0000, 1'b0, 0, 0, 0, 0, 0);
    tick(5);
    check("bp_req_ready", 64'(bus.req_ready), 64'd0);
    check("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("bp_inflight", 64'(exp_q.size()), 64'd2);
    bus.rsp_ready = 1'b1;
    wait_idle("backpressure", 40);

    bus.rsp_ready = 1'b0;
    push(1, 32'h11, 32'h22, 1'b0, 0, 0, 0, 0, 0);
    push(2, 32'h33, 32'h44, 1'b1, 0, 0, 0, 0, 0);
    tick(4);
    check("pre_reset_inflight", 64'(exp_q.size()), 64'd2);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_valid", 64'(bus.rsp_valid), 64'd0);
    check("post_reset_id", 64'(bus.rsp_id), 64'd0);
    check("post_reset_sum", 64'(bus.rsp_sum), 64'd0);
    check("post_reset_carry", 64'(bus.rsp_carry), 64'd0);
    check("post_reset_ovf", 64'(bus.rsp_overflow), 64'd0);
    tick(1);
    bus.rsp_ready = 1'b1;
    base = grant_log.size();
    for (int r = 0; r < N; r++) push(r, 32'h100 + r, 32'h10, 1'b0, 0, 0, 0, 0, 1);
    wait_idle("ptr_restart", 30);
    check("ptr_restart_count", 64'(grant_log.size() - base), 64'd3);
    for (int k = 0; k < N; k++)
      if (base + k < grant_log.size())
        check("ptr_restart_order", 64'(grant_log[base + k]), 64'(k));

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
